// File: rtl/qos_pkg.sv
// Shared constants and mode encoding for the four-VC QoS arbiter.
package qos_pkg;

   localparam int unsigned NUM_VC = 4;
   localparam int unsigned SLOTS  = 16;
   localparam int unsigned VC_W   = 2;
   localparam int unsigned SLOT_W = $clog2(SLOTS);
   localparam int unsigned TBL_W  = SLOTS * VC_W;
   localparam int unsigned CNT_W  = 16;

   typedef enum logic [1:0] {
      MODE_STRICT = 2'd0,
      MODE_RR     = 2'd1,
      MODE_WRR    = 2'd2,
      MODE_BURST  = 2'd3
   } mode_e;

endpackage

// File: rtl/wrr_vc_arbiter_if.sv
// Control, request and grant bundle between the QoS control block and the arbiter.
// Carries gnt_count only when GNT_COUNT_EN is defined.
interface wrr_vc_arbiter_if;
   import qos_pkg::*;

   logic                    enb;
   logic [1:0]              sel;
   logic [TBL_W-1:0]        wrr_table;
   logic [1:0]              weight;
   logic [NUM_VC-1:0]       req;
   logic                    out_ready;
   logic [NUM_VC-1:0]       gnt;
   logic                    valid_out;
   logic [VC_W-1:0]         gnt_vc;
`ifdef GNT_COUNT_EN
   logic [NUM_VC*CNT_W-1:0] gnt_count;
`endif

   modport master (
      output enb, sel, wrr_table, weight, req, out_ready,
`ifdef GNT_COUNT_EN
      input  gnt_count,
`endif
      input  gnt, valid_out, gnt_vc
   );

   modport slave (
      input  enb, sel, wrr_table, weight, req, out_ready,
`ifdef GNT_COUNT_EN
      output gnt_count,
`endif
      output gnt, valid_out, gnt_vc
   );

endinterface

// File: rtl/rr_pick.sv
// Rotating-priority picker: first requester at or after i_start, wrapping 3->0.
module rr_pick
   import qos_pkg::*;
(
   input  logic [NUM_VC-1:0] i_req,
   input  logic [VC_W-1:0]   i_start,
   output logic [VC_W-1:0]   o_vc_c,
   output logic              o_found_c
);

   always_comb begin
      logic [VC_W-1:0] w_idx;
      o_vc_c    = '0;
      o_found_c = 1'b0;
      w_idx     = '0;
      for (int unsigned i = 0; i < NUM_VC; i++) begin
         w_idx = VC_W'(i_start + VC_W'(i));
         if (!o_found_c && i_req[w_idx]) begin
            o_found_c = 1'b1;
            o_vc_c    = w_idx;
         end
      end
   end

endmodule

// File: rtl/wrr_vc_arbiter.sv
// Four-VC pop arbiter: strict, round-robin, table WRR and burst RR modes.
// Optional per-VC saturating grant counters under GNT_COUNT_EN.
module wrr_vc_arbiter
   import qos_pkg::*;
(
   input  logic             clk,
   input  logic             reset_L,
   wrr_vc_arbiter_if.slave  bus
);

   logic [NUM_VC-1:0] r_gnt;
   logic              r_valid;
   logic [VC_W-1:0]   r_gnt_vc;
   logic [VC_W-1:0]   r_rr_ptr;
   logic [SLOT_W-1:0] r_slot_ptr;
   logic [1:0]        r_burst_cnt;
   logic [VC_W-1:0]   r_last_vc;

   logic [NUM_VC-1:0] w_gnt_nxt;
   logic              w_valid_nxt;
   logic [VC_W-1:0]   w_gnt_vc_nxt;
   logic [VC_W-1:0]   w_rr_ptr_nxt;
   logic [SLOT_W-1:0] w_slot_ptr_nxt;
   logic [1:0]        w_burst_nxt;
   logic [VC_W-1:0]   w_last_vc_nxt;

   mode_e             w_mode;
   logic [VC_W-1:0]   w_pick_start;
   logic [VC_W-1:0]   w_pick_vc;
   logic              w_pick_found;
   logic [VC_W-1:0]   w_cand;
   logic              w_grant;
   logic [VC_W-1:0]   w_win;

   assign w_mode       = mode_e'(bus.sel);
   assign w_pick_start = (w_mode == MODE_STRICT) ? '0 : r_rr_ptr;
   assign w_cand       = bus.wrr_table[{r_slot_ptr, 1'b0} +: VC_W];

   rr_pick u_pick (
      .i_req     (bus.req),
      .i_start   (w_pick_start),
      .o_vc_c    (w_pick_vc),
      .o_found_c (w_pick_found)
   );

   // Winner selection and next pointer/burst state for one enabled cycle.
   always_comb begin
      w_gnt_nxt      = '0;
      w_valid_nxt    = 1'b0;
      w_gnt_vc_nxt   = '0;
      w_rr_ptr_nxt   = r_rr_ptr;
      w_slot_ptr_nxt = r_slot_ptr;
      w_burst_nxt    = r_burst_cnt;
      w_last_vc_nxt  = r_last_vc;
      w_grant        = 1'b0;
      w_win          = '0;

      if (bus.enb && bus.out_ready) begin
         case (w_mode)
            MODE_STRICT: begin
               w_grant     = w_pick_found;
               w_win       = w_pick_vc;
               w_burst_nxt = '0;
            end
            MODE_RR: begin
               w_grant     = w_pick_found;
               w_win       = w_pick_vc;
               w_burst_nxt = '0;
               if (w_pick_found) w_rr_ptr_nxt = VC_W'(w_pick_vc + 1'b1);
            end
            MODE_WRR: begin
               w_grant        = bus.req[w_cand];
               w_win          = w_cand;
               w_burst_nxt    = '0;
               w_slot_ptr_nxt = SLOT_W'(r_slot_ptr + 1'b1);
            end
            MODE_BURST: begin
               // Continue the current burst only while its VC keeps requesting.
               if (r_burst_cnt != '0 && bus.req[r_last_vc]) begin
                  w_grant     = 1'b1;
                  w_win       = r_last_vc;
                  w_burst_nxt = 2'(r_burst_cnt - 1'b1);
               end else begin
                  w_grant     = w_pick_found;
                  w_win       = w_pick_vc;
                  w_burst_nxt = w_pick_found ? bus.weight : '0;
                  if (w_pick_found) w_rr_ptr_nxt = VC_W'(w_pick_vc + 1'b1);
               end
            end
            default: ;
         endcase

         if (w_grant) begin
            w_gnt_nxt     = NUM_VC'(1) << w_win;
            w_valid_nxt   = 1'b1;
            w_gnt_vc_nxt  = w_win;
            w_last_vc_nxt = w_win;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_L) begin
         r_gnt       <= '0;
         r_valid     <= 1'b0;
         r_gnt_vc    <= '0;
         r_rr_ptr    <= '0;
         r_slot_ptr  <= '0;
         r_burst_cnt <= '0;
         r_last_vc   <= '0;
      end else begin
         r_gnt       <= w_gnt_nxt;
         r_valid     <= w_valid_nxt;
         r_gnt_vc    <= w_gnt_vc_nxt;
         r_rr_ptr    <= w_rr_ptr_nxt;
         r_slot_ptr  <= w_slot_ptr_nxt;
         r_burst_cnt <= w_burst_nxt;
         r_last_vc   <= w_last_vc_nxt;
      end
   end

   assign bus.gnt       = r_gnt;
   assign bus.valid_out = r_valid;
   assign bus.gnt_vc    = r_gnt_vc;

`ifdef GNT_COUNT_EN
   logic [NUM_VC*CNT_W-1:0] r_gnt_count;

   // Count grants as they are registered; each counter sticks at all-ones.
   always_ff @(posedge clk) begin
      if (!reset_L) begin
         r_gnt_count <= '0;
      end else begin
         for (int unsigned k = 0; k < NUM_VC; k++) begin
            if (w_gnt_nxt[k] && r_gnt_count[k*CNT_W +: CNT_W] != '1)
               r_gnt_count[k*CNT_W +: CNT_W] <= CNT_W'(r_gnt_count[k*CNT_W +: CNT_W] + 1'b1);
         end
      end
   end

   assign bus.gnt_count = r_gnt_count;
`endif

endmodule

// File: tb/tb_wrr_vc_arbiter.sv
// Self-checking bench for wrr_vc_arbiter: directed literal checks plus a random run
// compared every cycle against a behavioural model. Exercises counters under GNT_COUNT_EN.
module tb_wrr_vc_arbiter;

   logic clk;
   logic reset_L;
   int   total;
   int   bad;

   wrr_vc_arbiter_if bus ();

   wrr_vc_arbiter dut (
      .clk     (clk),
      .reset_L (reset_L),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural model state
   int         m_rr;
   int         m_slot;
   int         m_left;
   int         m_last;
   logic [3:0] m_gnt;
   logic       m_valid;
   logic [1:0] m_vc;
   int         m_cnt [4];

   function automatic int first_req(logic [3:0] r, int start);
      for (int i = 0; i < 4; i++) begin
         if (r[(start + i) % 4]) return (start + i) % 4;
      end
      return -1;
   endfunction

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Advance the model by one edge using the inputs currently applied.
   task automatic model_step();
      int win;
      int c;
      win = -1;
      if (!reset_L) begin
         m_rr = 0; m_slot = 0; m_left = 0; m_last = 0;
         for (int k = 0; k < 4; k++) m_cnt[k] = 0;
      end else if (bus.enb && bus.out_ready) begin
         case (bus.sel)
            2'd0: begin m_left = 0; win = first_req(bus.req, 0); end
            2'd1: begin
               m_left = 0;
               win = first_req(bus.req, m_rr);
               if (win >= 0) m_rr = (win + 1) % 4;
            end
            2'd2: begin
               m_left = 0;
               c = int'((bus.wrr_table >> (2 * m_slot)) & 32'd3);
               if (bus.req[c]) win = c;
               m_slot = (m_slot + 1) % 16;
            end
            default: begin
               if (m_left > 0 && bus.req[m_last]) begin
                  win = m_last;
                  m_left = m_left - 1;
               end else begin
                  win = first_req(bus.req, m_rr);
                  m_left = (win >= 0) ? int'(bus.weight) : 0;
                  if (win >= 0) m_rr = (win + 1) % 4;
               end
            end
         endcase
      end
      m_gnt = 4'b0; m_valid = 1'b0; m_vc = 2'd0;
      if (win >= 0) begin
         m_gnt   = 4'(1 << win);
         m_valid = 1'b1;
         m_vc    = 2'(win);
         m_last  = win;
         if (m_cnt[win] < 65535) m_cnt[win] = m_cnt[win] + 1;
      end
   endtask

   // One clock: update model, take the edge, compare all outputs.
   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
      chk("gnt", 64'(bus.gnt), 64'(m_gnt));
      chk("valid_out", 64'(bus.valid_out), 64'(m_valid));
      chk("gnt_vc", 64'(bus.gnt_vc), 64'(m_vc));
`ifdef GNT_COUNT_EN
      for (int k = 0; k < 4; k++)
         chk($sformatf("gnt_count%0d", k), 64'(bus.gnt_count[k*16 +: 16]), 64'(m_cnt[k]));
`endif
   endtask

   task automatic do_reset();
      reset_L = 1'b0;
      cycle();
      cycle();
      reset_L = 1'b1;
   endtask

   initial begin
      logic [3:0] exp_seq [5];
      total = 0;
      bad   = 0;
      reset_L       = 1'b0;
      bus.enb       = 1'b1;
      bus.sel       = 2'd1;
      bus.wrr_table = 32'h0;
      bus.weight    = 2'd0;
      bus.req       = 4'hF;
      bus.out_ready = 1'b1;

      // Reset held two edges with all requests asserted
      do_reset();
      chk("rst_gnt", 64'(bus.gnt), 64'h0);
      chk("rst_valid", 64'(bus.valid_out), 64'h0);
      exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0010; exp_seq[2] = 4'b0100;
      exp_seq[3] = 4'b1000; exp_seq[4] = 4'b0001;
      for (int i = 0; i < 5; i++) begin
         cycle();
         chk($sformatf("rr_seq%0d", i), 64'(bus.gnt), 64'(exp_seq[i]));
      end

      // Strict priority
      bus.sel = 2'd0;
      bus.req = 4'b1010;
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("strict_1010", 64'(bus.gnt), 64'h2);
      end
      bus.req = 4'b1000;
      cycle();
      chk("strict_1000", 64'(bus.gnt), 64'h8);

      // Table WRR
      bus.sel = 2'd2;
      bus.wrr_table = 32'hB19E6F92;
      bus.req = 4'hF;
      do_reset();
      exp_seq[0] = 4'b0100; exp_seq[1] = 4'b0001; exp_seq[2] = 4'b0010; exp_seq[3] = 4'b0100;
      for (int i = 0; i < 4; i++) begin
         cycle();
         chk($sformatf("wrr_slot%0d", i), 64'(bus.gnt), 64'(exp_seq[i]));
      end
      bus.req = 4'b1011;
      do_reset();
      cycle();
      chk("wrr_skip_valid", 64'(bus.valid_out), 64'h0);
      cycle();
      chk("wrr_slot1_gnt", 64'(bus.gnt), 64'h1);

      // Burst RR, weight 2
      bus.sel = 2'd3;
      bus.weight = 2'd2;
      bus.req = 4'hF;
      do_reset();
      for (int i = 0; i < 9; i++) begin
         cycle();
         chk($sformatf("burst_vc%0d", i), 64'(bus.gnt_vc), 64'(i / 3));
      end

      // Burst broken by request drop
      bus.weight = 2'd3;
      do_reset();
      cycle();
      cycle();
      chk("burst_pre_drop", 64'(bus.gnt), 64'h1);
      bus.req = 4'b1110;
      cycle();
      chk("burst_after_drop", 64'(bus.gnt), 64'h2);

      // Back-pressure in round-robin
      bus.sel = 2'd1;
      bus.req = 4'hF;
      do_reset();
      cycle();
      cycle();
      chk("bp_before", 64'(bus.gnt), 64'h2);
      bus.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("bp_stall", 64'(bus.gnt), 64'h0);
      end
      bus.out_ready = 1'b1;
      cycle();
      chk("bp_resume", 64'(bus.gnt), 64'h4);

`ifdef GNT_COUNT_EN
      do_reset();
      for (int i = 0; i < 20; i++) cycle();
      for (int k = 0; k < 4; k++)
         chk($sformatf("cnt20_vc%0d", k), 64'(bus.gnt_count[k*16 +: 16]), 64'd5);
      bus.sel = 2'd0;
      bus.req = 4'b0001;
      for (int i = 0; i < 65540; i++) cycle();
      chk("cnt_sat", 64'(bus.gnt_count[15:0]), 64'hFFFF);
`endif

      // Randomized run against the model
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 49) == 0) bus.sel = 2'($urandom);
         if ($urandom_range(0, 19) == 0) bus.weight = 2'($urandom);
         if ($urandom_range(0, 99) == 0) bus.wrr_table = $urandom;
         bus.req       = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom);
         bus.enb       = ($urandom_range(0, 9) != 0);
         bus.out_ready = ($urandom_range(0, 7) != 0);
         reset_L       = ($urandom_range(0, 299) != 0);
         cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
